// File: rtl/uart_rx_line_receiver.sv
// 8N1 UART line receiver: bytes into an LF/full-buffer message bus (byte 0 in MSBs); UART_RX_FRAME_CHECK_EN drops bad-stop bytes.
// Latency: rx->rx_s 2 cycles, byte_valid the cycle after the mid-stop sample, msg_valid one cycle after the terminating byte_valid.
// Backpressure: none; byte_valid, msg_valid and frame_err are single-cycle pulses that the consumer must capture.
module uart_rx_line_receiver #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int MSG_BYTES = 14
) (
    input  logic                   clk_50M,
    input  logic                   rst_n,
    input  logic                   rx,
    output logic                   byte_valid,
    output logic [7:0]             byte_data,
    output logic                   msg_valid,
    output logic [3:0]             msg_len,
    output logic [8*MSG_BYTES-1:0] msg_data,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int IW           = $clog2(MSG_BYTES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            brk_q;
    logic            rx_meta_q;
    logic            rx_s_q;
    logic            byte_valid_q;
    logic [7:0]      byte_data_q;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

`ifdef UART_RX_FRAME_CHECK_EN
    logic frame_err_q;
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    // A low stop sample arms brk_q so a held-low line yields one byte, then parks in IDLE until rx_s rises.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            brk_q        <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
`ifdef UART_RX_FRAME_CHECK_EN
            frame_err_q  <= 1'b0;
`endif
        end else begin
            byte_valid_q <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
            frame_err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (brk_q) begin
                        if (rx_s_q) brk_q <= 1'b0;
                    end else if (!rx_s_q) begin
                        cnt_q   <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rx_s_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        brk_q   <= !rx_s_q;
`ifdef UART_RX_FRAME_CHECK_EN
                        if (rx_s_q) begin
                            byte_valid_q <= 1'b1;
                            byte_data_q  <= shift_q;
                        end else begin
                            frame_err_q  <= 1'b1;
                        end
`else
                        byte_valid_q <= 1'b1;
                        byte_data_q  <= shift_q;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;

    logic [7:0]             work_q [MSG_BYTES];
    logic [7:0]             work_d [MSG_BYTES];
    logic [8*MSG_BYTES-1:0] img_d;
    logic [IW-1:0]          wr_idx_q;
    logic                   wr_en;
    logic                   msg_valid_q;
    logic [3:0]             msg_len_q;
    logic [8*MSG_BYTES-1:0] msg_data_q;

    assign wr_en = byte_valid_q && (byte_data_q != 8'h0A) && (byte_data_q != 8'h0D);

    // img_d is the buffer including the incoming byte, so a full-buffer publish carries its last byte.
    always_comb begin
        img_d = '0;
        for (int i = 0; i < MSG_BYTES; i++) begin
            work_d[i] = (wr_en && (IW'(i) == wr_idx_q)) ? byte_data_q : work_q[i];
            img_d[8*(MSG_BYTES-i)-1 -: 8] = work_d[i];
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q    <= '0;
            msg_valid_q <= 1'b0;
            msg_len_q   <= '0;
            msg_data_q  <= {MSG_BYTES{8'h20}};
            for (int i = 0; i < MSG_BYTES; i++) work_q[i] <= 8'h20;
        end else begin
            msg_valid_q <= 1'b0;
            if (byte_valid_q) begin
                if (byte_data_q == 8'h0A) begin
                    if (wr_idx_q != '0) begin
                        msg_valid_q <= 1'b1;
                        msg_len_q   <= 4'(wr_idx_q);
                        msg_data_q  <= img_d;
                        wr_idx_q    <= '0;
                        for (int i = 0; i < MSG_BYTES; i++) work_q[i] <= 8'h20;
                    end
                end else if (byte_data_q != 8'h0D) begin
                    if (wr_idx_q == IW'(MSG_BYTES - 1)) begin
                        msg_valid_q <= 1'b1;
                        msg_len_q   <= 4'(MSG_BYTES);
                        msg_data_q  <= img_d;
                        wr_idx_q    <= '0;
                        for (int i = 0; i < MSG_BYTES; i++) work_q[i] <= 8'h20;
                    end else begin
                        wr_idx_q <= wr_idx_q + 1'b1;
                        for (int i = 0; i < MSG_BYTES; i++) work_q[i] <= work_d[i];
                    end
                end
            end
        end
    end

    assign msg_valid = msg_valid_q;
    assign msg_len   = msg_len_q;
    assign msg_data  = msg_data_q;

endmodule

// File: tb/tb_uart_rx_line_receiver.sv
// Bench for uart_rx_line_receiver: serial stimulus per scenario, scoreboard of expected bytes, messages and frame errors.
// Runs at 16 clocks per bit (1.8432 MHz clock, 115200 baud) to keep the run short.
module tb_uart_rx_line_receiver;

    localparam int CLK_HZ = 1843200;
    localparam int BAUD   = 115200;
    localparam int MB     = 14;
    localparam int CPB    = CLK_HZ / BAUD;

    logic            clk_50M = 1'b0;
    logic            rst_n   = 1'b0;
    logic            rx      = 1'b1;
    logic            byte_valid;
    logic [7:0]      byte_data;
    logic            msg_valid;
    logic [3:0]      msg_len;
    logic [8*MB-1:0] msg_data;
    logic            frame_err;
    logic            busy;

    uart_rx_line_receiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .MSG_BYTES(MB)) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .rx(rx),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .msg_valid(msg_valid), .msg_len(msg_len), .msg_data(msg_data),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk_50M = ~clk_50M;

    typedef struct {
        int              len;
        logic [8*MB-1:0] data;
    } msg_t;

    logic [7:0]      exp_bytes[$];
    msg_t            exp_msgs[$];
    int              exp_ferr = 0;
    int              checks   = 0;
    int              failures = 0;
    int              cyc      = 0;
    int              last_bv_cyc = -10;
    logic [7:0]      mon_b;
    msg_t            mon_m;
    logic [8*MB-1:0] spaces = {MB{8'h20}};

    always @(posedge clk_50M) cyc <= cyc + 1;

    // Scoreboard: every DUT pulse is matched against the oldest expectation.
    always @(negedge clk_50M) begin
        if (byte_valid) begin
            checks++;
            if (exp_bytes.size() == 0) begin
                failures++;
                $display("FAIL unexpected_byte got=%02h required=none", byte_data);
            end else begin
                mon_b = exp_bytes.pop_front();
                if (byte_data !== mon_b) begin
                    failures++;
                    $display("FAIL byte_data got=%02h required=%02h", byte_data, mon_b);
                end
            end
            last_bv_cyc = cyc;
        end
        if (msg_valid) begin
            checks++;
            if (exp_msgs.size() == 0) begin
                failures++;
                $display("FAIL unexpected_msg got_len=%0d required=none", msg_len);
            end else begin
                mon_m = exp_msgs.pop_front();
                if (msg_len !== 4'(mon_m.len) || msg_data !== mon_m.data) begin
                    failures++;
                    $display("FAIL msg got_len=%0d got=%h required_len=%0d required=%h",
                             msg_len, msg_data, mon_m.len, mon_m.data);
                end
            end
            checks++;
            if (cyc - last_bv_cyc !== 1) begin
                failures++;
                $display("FAIL msg_lag got=%0d required=1", cyc - last_bv_cyc);
            end
        end
        if (frame_err) begin
            checks++;
            if (exp_ferr == 0) begin
                failures++;
                $display("FAIL unexpected_frame_err got=1 required=0");
            end else begin
                exp_ferr--;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_bytes.push_back(s[i]);
    endtask

    function automatic msg_t mk(input string s);
        msg_t m;
        m.len  = s.len();
        m.data = {MB{8'h20}};
        for (int i = 0; i < s.len(); i++) m.data[8*(MB-i)-1 -: 8] = s[i];
        return m;
    endfunction

    task automatic drain(input string name);
        tick(3 * CPB);
        checks++;
        if (exp_bytes.size() != 0 || exp_msgs.size() != 0 || exp_ferr != 0) begin
            failures++;
            $display("FAIL %s_pending got_bytes=%0d got_msgs=%0d got_ferr=%0d required=0",
                     name, exp_bytes.size(), exp_msgs.size(), exp_ferr);
        end
        exp_bytes.delete();
        exp_msgs.delete();
        exp_ferr = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        tick(3);
        checks++;
        if ({byte_valid, msg_valid, frame_err, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pulses got=%b required=0000", {byte_valid, msg_valid, frame_err, busy});
        end
        checks++;
        if (byte_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_byte_data got=%02h required=00", byte_data);
        end
        checks++;
        if (msg_len !== 4'd0) begin
            failures++;
            $display("FAIL reset_msg_len got=%0d required=0", msg_len);
        end
        checks++;
        if (msg_data !== spaces) begin
            failures++;
            $display("FAIL reset_msg_data got=%h required=%h", msg_data, spaces);
        end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_line;
        push_str("RaunakArora");
        exp_bytes.push_back(8'h0A);
        exp_msgs.push_back(mk("RaunakArora"));
        send_str("RaunakArora");
        send_byte(8'h0A, 1'b1);
        drain("line");
        checks++;
        if (msg_len !== 4'd11) begin
            failures++;
            $display("FAIL line_hold_len got=%0d required=11", msg_len);
        end
    endtask

    task automatic test_full_buffer;
        push_str("ABCDEFGHIJKLMN");
        exp_msgs.push_back(mk("ABCDEFGHIJKLMN"));
        send_str("ABCDEFGHIJKLMN");
        exp_bytes.push_back(8'h0A);
        send_byte(8'h0A, 1'b1);
        drain("full_buffer");
        checks++;
        if (msg_len !== 4'd14) begin
            failures++;
            $display("FAIL full_hold_len got=%0d required=14", msg_len);
        end
    endtask

    task automatic test_glitch;
        logic seen;
        seen = 1'b0;
        rx   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            seen = seen | busy;
        end
        rx = 1'b1;
        for (int i = 0; i < 4 * CPB && !(seen && !busy); i++) begin
            tick(1);
            seen = seen | busy;
        end
        checks++;
        if (seen !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy got_seen=%b got_busy=%b required_seen=1 required_busy=0", seen, busy);
        end
        drain("glitch");
    endtask

    task automatic test_frame_error;
        exp_bytes.push_back(8'h51);
`ifdef UART_RX_FRAME_CHECK_EN
        exp_ferr = 1;
        exp_msgs.push_back(mk("Q"));
`else
        exp_bytes.push_back(8'h41);
        exp_msgs.push_back(mk("QA"));
`endif
        exp_bytes.push_back(8'h0A);
        send_byte(8'h51, 1'b1);
        send_byte(8'h41, 1'b0);
        tick(CPB);
        send_byte(8'h0A, 1'b1);
        drain("frame_error");
    endtask

    task automatic test_break;
        msg_t m;
`ifdef UART_RX_FRAME_CHECK_EN
        exp_ferr = 1;
`else
        exp_bytes.push_back(8'h00);
        m.len  = 1;
        m.data = {8'h00, {(MB-1){8'h20}}};
        exp_msgs.push_back(m);
`endif
        exp_bytes.push_back(8'h0A);
        rx = 1'b0;
        tick(12 * CPB);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL break_parked got_busy=%b required=0", busy);
        end
        rx = 1'b1;
        tick(CPB);
        send_byte(8'h0A, 1'b1);
        drain("break");
    endtask

    task automatic test_cr_lf;
        exp_bytes.push_back(8'h41);
        exp_bytes.push_back(8'h0D);
        exp_bytes.push_back(8'h0A);
        exp_msgs.push_back(mk("A"));
        send_byte(8'h41, 1'b1);
        send_byte(8'h0D, 1'b1);
        send_byte(8'h0A, 1'b1);
        drain("cr_lf");
        checks++;
        if (msg_data[8*MB-1 -: 8] !== 8'h41 || msg_data[8*(MB-1)-1:0] !== spaces[8*(MB-1)-1:0]) begin
            failures++;
            $display("FAIL cr_lf_data got=%h required=41 then spaces", msg_data);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        b = 8'h55;
        exp_bytes.push_back(8'h58);
        send_byte(8'h58, 1'b1);
        tick(CPB);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = b[4];
        tick(CPB / 2);
        rst_n = 1'b0;
        tick(2);
        checks++;
        if (busy !== 1'b0 || msg_len !== 4'd0 || msg_data !== spaces) begin
            failures++;
            $display("FAIL midframe_reset got_busy=%b got_len=%0d got=%h required_busy=0 required_len=0",
                     busy, msg_len, msg_data);
        end
        rx    = 1'b1;
        rst_n = 1'b1;
        tick(CPB);
        push_str("Hi");
        exp_bytes.push_back(8'h0A);
        exp_msgs.push_back(mk("Hi"));
        send_str("Hi");
        send_byte(8'h0A, 1'b1);
        drain("midframe");
        checks++;
        if (msg_data[8*MB-1 -: 16] !== 16'h4869 || msg_len !== 4'd2) begin
            failures++;
            $display("FAIL midframe_msg got_len=%0d got=%h required_len=2 required_head=4869", msg_len, msg_data);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_full_buffer();
        test_glitch();
        test_frame_error();
        test_break();
        test_cr_lf();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
